psum_collector: RTL
===================

Name: psum_collector

Overview:
- Partial-sum collector for the 16-lane MAC array.
- Holds one 16-lane × 24-bit partial-sum vector per accumulation address (ad_idx 0..15).
- Each cycle it supplies the array's partial_sum_in for the addressed entry and captures the array's combinational result at the clock edge.
- On the last reduction chunk, the finished vector goes to a one-entry output register with a valid/ready handshake toward the downstream requant/writeback stage.

Parameters:
- LANES, 16, number of MAC lanes (vector length).
- ADDRS, 16, number of accumulation entries.
- PSUM_W, 24, partial-sum width per lane.
- AW, 4, address width (log2 ADDRS).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous flush: invalidates all entries and clears err; the output register is untouched.
- in_valid  input  1  a MAC operation is presented this cycle.
- in_ready  output  1  collector can accept the operation.
- in_addr  input  AW  accumulation entry (ad_idx) of this operation.
- in_first  input  1  first reduction chunk for this entry; the supplied partial sum is zero.
- in_last  input  1  last reduction chunk; the result is emitted instead of stored.
- psum_rd  output  LANES*PSUM_W  partial_sum_in to the MAC array, lane i at bits [i*24 +: 24].
- mac_result  input  LANES*PSUM_W  MAC array result, same packing.
- out_valid  output  1  finished vector available.
- out_ready  input  1  downstream accepts.
- out_data  output  LANES*PSUM_W  finished vector.
- out_addr  output  AW  entry the vector belongs to.
- live_cnt  output  AW+1  number of entries currently holding a partial sum.
- err  output  1  sticky protocol error.

Behaviour:
- Reset:
  - All live bits = 0; storage contents don't-care.
  - out_valid = 0, out_data = 0, out_addr = 0, live_cnt = 0, err = 0.
- psum_rd is combinational, with zero latency, in the same cycle as in_addr:
  - 0 if in_first = 1 or the entry is not live;
  - otherwise mem[in_addr].
  - psum_rd is driven regardless of in_valid.
- Accept condition: in_valid && in_ready.
- in_ready = !out_valid || out_ready, combinational. There is no skid buffer.
- Accept with in_last = 0:
  - mem[in_addr] <= mac_result;
  - live[in_addr] <= 1.
- Accept with in_last = 1:
  - out_data <= mac_result; out_addr <= in_addr; out_valid <= 1;
  - live[in_addr] <= 0.
- in_first && in_last together is legal (single-chunk reduction): the result is emitted, no storage is written, and the entry ends not live.
- Output register states:
  - EMPTY (out_valid = 0) → FULL on an accept with in_last.
  - FULL → EMPTY on out_ready with no new last-accept.
  - FULL stays FULL, reloading with the new data, when out_ready and a last-accept occur in the same cycle.
  - While FULL && !out_ready: out_data and out_addr are stable and in_ready = 0.
- Arithmetic: the collector does no arithmetic. Values wrap mod 2^24 in the array; the collector stores bits unchanged.
- err is set, sticky until rst or clr, when an operation is accepted with either:
  - in_first = 0 on an entry that is not live (the operation still proceeds with psum_rd = 0); or
  - in_first = 1 on an entry that is already live (the old sum is discarded and overwritten).
- live_cnt equals the popcount of the live bits and is updated in the same cycle as the live bits. Maximum value is 16 with all entries live.
- clr:
  - live bits → 0 and err → 0.
  - An operation accepted in the same cycle is dropped for storage purposes: clr wins and the entry ends not live.
  - A last-accept in the clr cycle still loads the output register.
  - live_cnt = 0 on the next cycle.
- rst mid-operation discards all state, including a pending output; out_valid = 0 on the next cycle.
- A read and write to the same address in one cycle returns the old value on psum_rd. This is read-before-write; there is no bypass, because the array is combinational and reads and writes the same entry each cycle by construction.

Test Plan:
- Single-chunk reduction:
  - Input: rst; then accept addr 3 with first = last = 1 and mac_result lane0 = 0x000010.
  - Expected: psum_rd = 0 that cycle; out_valid = 1 next cycle; out_addr = 3, out_data lane0 = 0x000010; live_cnt stays 0.
- Three-chunk accumulation:
  - Input: addr 5, three accepts in consecutive cycles with first, mid, last flags. Bench models mac_result = psum_rd + 7 on every lane.
  - Expected: psum_rd sequence 0, 7, 14; out_data = 21 on all lanes; live_cnt 0 → 1 → 1 → 0.
- Interleaved addresses:
  - Input: all 16 addresses started with first = 1 (live_cnt reaches 16), then each finished with last = 1 in order 15..0, with out_ready = 1.
  - Expected: 16 outputs in order 15..0 with correct per-address data; final live_cnt = 0.
- Backpressure:
  - Input: out_ready = 0 with out_valid = 1; present a last-accept on addr 2.
  - Expected: in_ready = 0; out_data is held. After out_ready = 1 for one cycle, addr 2 is accepted and appears next cycle; no value is lost or duplicated.
- Error and clear:
  - Input: accept addr 9 with first = 0 while not live.
  - Expected: err = 1 and psum_rd = 0.
  - Input: then clr while addr 4 is live.
  - Expected: err = 0 and live_cnt = 0; a following first = 0 op on addr 4 reads 0 and sets err.
- Reset mid-accumulation:
  - Input: addr 1 live with 0x00ABCD and out_valid = 1; assert rst for one cycle.
  - Expected: out_valid = 0, live_cnt = 0, err = 0; the next op on addr 1 with first = 0 reads psum_rd = 0.

Source files
------------

// File: rtl/psum_collector.sv
// Partial-sum collector for the 16-lane MAC array.
// Keeps one running partial-sum vector per accumulation entry, feeds it back
// to the array each cycle and hands finished vectors to the writeback stage
// through a single output register with a valid/ready handshake.

// One lane's slice of the accumulation storage. Reads are combinational and
// see the value stored before this cycle's write.
module psum_lane #(
  parameter int ADDRS  = 16,
  parameter int PSUM_W = 24,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [PSUM_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  input  logic              rzero,
  output logic [PSUM_W-1:0] rdata
);
  logic [PSUM_W-1:0] mem [ADDRS];

  // Storage has no reset; the live bits in the top decide what is meaningful.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = rzero ? '0 : mem[raddr];
endmodule

module psum_collector #(
  parameter int LANES  = 16,
  parameter int ADDRS  = 16,
  parameter int PSUM_W = 24,
  parameter int AW     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [AW-1:0]           in_addr,
  input  logic                    in_first,
  input  logic                    in_last,
  output logic [LANES*PSUM_W-1:0] psum_rd,
  input  logic [LANES*PSUM_W-1:0] mac_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*PSUM_W-1:0] out_data,
  output logic [AW-1:0]           out_addr,
  output logic [AW:0]             live_cnt,
  output logic                    err
);
  typedef enum logic {EMPTY, FULL} ostate_t;

  ostate_t           ost, ost_nxt;
  logic [ADDRS-1:0]  live;
  logic              accept, last_acc, st_we, rd_zero;

  assign accept   = in_valid && in_ready;
  assign last_acc = accept && in_last;
  // clr wins over a same-cycle store, so the write is suppressed outright.
  assign st_we    = accept && !in_last && !clr;
  assign rd_zero  = in_first || !live[in_addr];

  assign out_valid = (ost == FULL);
  assign in_ready  = !out_valid || out_ready;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    psum_lane #(.ADDRS(ADDRS), .PSUM_W(PSUM_W), .AW(AW)) u_lane (
      .clk   (clk),
      .we    (st_we),
      .waddr (in_addr),
      .wdata (mac_result[g*PSUM_W +: PSUM_W]),
      .raddr (in_addr),
      .rzero (rd_zero),
      .rdata (psum_rd[g*PSUM_W +: PSUM_W])
    );
  end

  // Live bits and sticky error; clr flushes both, regardless of any accept.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      live <= '0;
      err  <= 1'b0;
    end else if (accept) begin
      live[in_addr] <= !in_last;
      if (in_first == live[in_addr]) err <= 1'b1;
    end
  end

  // Population count of live entries, tracking the live bits directly.
  always_comb begin
    live_cnt = '0;
    for (int i = 0; i < ADDRS; i++) live_cnt = live_cnt + (AW+1)'(live[i]);
  end

  // Output register state.
  always_ff @(posedge clk) begin
    if (rst) ost <= EMPTY;
    else     ost <= ost_nxt;
  end

  // EMPTY fills on a last-accept; FULL drains on out_ready unless reloaded.
  always_comb begin
    ost_nxt = ost;
    case (ost)
      EMPTY: if (last_acc) ost_nxt = FULL;
      FULL:  if (out_ready && !last_acc) ost_nxt = EMPTY;
      default: ost_nxt = EMPTY;
    endcase
  end

  // Output payload; only moves on a last-accept so it is stable under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_addr <= '0;
    end else if (last_acc) begin
      out_data <= mac_result;
      out_addr <= in_addr;
    end
  end
endmodule
